universal_shift_reg: RTL and testbench



---
 rtl/usr_pkg.sv | 15 +
 rtl/usr_next_state.sv | 79 +++++++
 rtl/universal_shift_reg.sv | 52 +++++
 tb/tb_universal_shift_reg.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode encodings and widths.
package usr_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD = 3'd0;
  localparam logic [MODE_W-1:0] MODE_LOAD = 3'd1;
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'd2;
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'd3;
  localparam logic [MODE_W-1:0] MODE_ROL  = 3'd4;
  localparam logic [MODE_W-1:0] MODE_ROR  = 3'd5;
  localparam logic [MODE_W-1:0] MODE_INC  = 3'd6;
  localparam logic [MODE_W-1:0] MODE_DEC  = 3'd7;

endpackage

// File: rtl/usr_next_state.sv
// Combinational next-value logic for the universal shift register:
// produces the next register contents and carry/borrow/shift-out flag for a given mode.
module usr_next_state
  import usr_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int SATURATE = 0
) (
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  cur_data,
  input  logic              cur_flag_c,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              ser_in_l,
  input  logic              ser_in_r,
  output logic [WIDTH-1:0]  next_data,
  output logic              next_flag_c
);

  logic [WIDTH:0] inc_sum;
  logic [WIDTH:0] dec_diff;
  logic           all_ones;
  logic           all_zero;

  assign inc_sum  = {1'b0, cur_data} + {{WIDTH{1'b0}}, 1'b1};
  assign dec_diff = {1'b0, cur_data} - {{WIDTH{1'b0}}, 1'b1};
  assign all_ones = &cur_data;
  assign all_zero = ~|cur_data;

  always_comb begin
    next_data   = cur_data;
    next_flag_c = cur_flag_c;
    case (mode)
      MODE_LOAD: begin
        next_data   = data_in;
        next_flag_c = 1'b0;
      end
      MODE_SHL: begin
        next_data   = {cur_data[WIDTH-2:0], ser_in_l};
        next_flag_c = cur_data[WIDTH-1];
      end
      MODE_SHR: begin
        next_data   = {ser_in_r, cur_data[WIDTH-1:1]};
        next_flag_c = cur_data[0];
      end
      MODE_ROL: begin
        next_data   = {cur_data[WIDTH-2:0], cur_data[WIDTH-1]};
        next_flag_c = cur_data[WIDTH-1];
      end
      MODE_ROR: begin
        next_data   = {cur_data[0], cur_data[WIDTH-1:1]};
        next_flag_c = cur_data[0];
      end
      MODE_INC: begin
        // Saturating counters pin at the rail and report the clamp through flag_c.
        if (SATURATE != 0 && all_ones) begin
          next_data   = cur_data;
          next_flag_c = 1'b1;
        end else begin
          next_data   = inc_sum[WIDTH-1:0];
          next_flag_c = inc_sum[WIDTH];
        end
      end
      MODE_DEC: begin
        if (SATURATE != 0 && all_zero) begin
          next_data   = cur_data;
          next_flag_c = 1'b1;
        end else begin
          next_data   = dec_diff[WIDTH-1:0];
          next_flag_c = dec_diff[WIDTH];
        end
      end
      default: begin
        next_data   = cur_data;
        next_flag_c = cur_flag_c;
      end
    endcase
  end

endmodule

// File: rtl/universal_shift_reg.sv
// WIDTH-bit register with hold/load/shift/rotate/inc/dec modes, a registered
// carry/borrow/shift-out flag and a combinational zero flag.
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               SATURATE    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              ser_in_l,
  input  logic              ser_in_r,
  output logic [WIDTH-1:0]  data_out,
  output logic              flag_c,
  output logic              flag_z
);

  logic [WIDTH-1:0] next_data;
  logic             next_flag_c;

  usr_next_state #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_next (
    .mode        (mode),
    .cur_data    (data_out),
    .cur_flag_c  (flag_c),
    .data_in     (data_in),
    .ser_in_l    (ser_in_l),
    .ser_in_r    (ser_in_r),
    .next_data   (next_data),
    .next_flag_c (next_flag_c)
  );

  // Reset wins over enable, so an operation in flight is dropped whole.
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_out <= RESET_VALUE;
      flag_c   <= 1'b0;
    end else if (en) begin
      data_out <= next_data;
      flag_c   <= next_flag_c;
    end
  end

  assign flag_z = (data_out == '0);

endmodule

// File: tb/tb_universal_shift_reg.sv
// Bench for universal_shift_reg: a wrapping and a saturating instance driven in
// lockstep, checked against directed expectations and an arithmetic reference model.
module tb_universal_shift_reg;
  import usr_pkg::*;

  typedef struct packed {
    logic       rst;
    logic       en;
    logic [2:0] mode;
    logic [7:0] din;
    logic       sl;
    logic       sr;
    logic [7:0] e0;
    logic       c0;
    logic [7:0] e1;
    logic       c1;
  } step_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [2:0] mode = MODE_HOLD;
  logic [7:0] data_in = 8'h00;
  logic       ser_in_l = 1'b0;
  logic       ser_in_r = 1'b0;
  logic [7:0] d0, d1;
  logic       fc0, fc1, fz0, fz1;

  int total = 0;
  int bad = 0;
  int mv[2];
  int mc[2];

  always #5 clk = ~clk;

  universal_shift_reg #(.WIDTH(8), .RESET_VALUE(8'h00), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .data_in(data_in),
    .ser_in_l(ser_in_l), .ser_in_r(ser_in_r),
    .data_out(d0), .flag_c(fc0), .flag_z(fz0)
  );

  universal_shift_reg #(.WIDTH(8), .RESET_VALUE(8'h00), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .data_in(data_in),
    .ser_in_l(ser_in_l), .ser_in_r(ser_in_r),
    .data_out(d1), .flag_c(fc1), .flag_z(fz1)
  );

  function automatic step_t mk(logic r, logic e, logic [2:0] m, logic [7:0] di, logic l, logic s,
                               logic [7:0] x0, logic y0, logic [7:0] x1, logic y1);
    step_t t;
    t = '{r, e, m, di, l, s, x0, y0, x1, y1};
    return t;
  endfunction

  // Reference model in plain integer arithmetic on the 0..255 value range.
  function automatic void model_step(int idx, bit sat);
    int v;
    int c;
    v = mv[idx];
    c = mc[idx];
    if (!rst) begin
      v = 0;
      c = 0;
    end else if (en) begin
      case (int'(mode))
        1: begin v = int'(data_in); c = 0; end
        2: begin c = v / 128; v = (v * 2) % 256 + int'(ser_in_l); end
        3: begin c = v % 2; v = v / 2 + int'(ser_in_r) * 128; end
        4: begin c = v / 128; v = (v * 2) % 256 + v / 128; end
        5: begin c = v % 2; v = v / 2 + (v % 2) * 128; end
        6: begin
          if (v == 255) begin
            c = 1;
            if (!sat) v = 0;
          end else begin
            v = v + 1; c = 0;
          end
        end
        7: begin
          if (v == 0) begin
            c = 1;
            if (!sat) v = 255;
          end else begin
            v = v - 1; c = 0;
          end
        end
        default: ;
      endcase
    end
    mv[idx] = v;
    mc[idx] = c;
  endfunction

  task automatic drive(step_t s);
    rst = s.rst; en = s.en; mode = s.mode; data_in = s.din;
    ser_in_l = s.sl; ser_in_r = s.sr;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0, 1'b0);
    model_step(1, 1'b1);
    @(negedge clk);
  endtask

  task automatic test_reset();
    step_t tbl[$];
    tbl = '{mk(0, 1, MODE_LOAD, 8'hFF, 0, 0, 8'h00, 0, 8'h00, 0),
            mk(0, 1, MODE_LOAD, 8'hFF, 0, 0, 8'h00, 0, 8'h00, 0),
            mk(1, 1, MODE_LOAD, 8'hA5, 0, 0, 8'hA5, 0, 8'hA5, 0)};
    foreach (tbl[i]) begin
      drive(tbl[i]);
      tick();
      total++;
      if ({d0, fc0, fz0} !== {tbl[i].e0, tbl[i].c0, (tbl[i].e0 == 8'h00)}) begin
        bad++;
        $display("FAIL reset[%0d] wrap: got d=%h c=%b z=%b want d=%h c=%b", i, d0, fc0, fz0, tbl[i].e0, tbl[i].c0);
      end
      total++;
      if ({d1, fc1, fz1} !== {tbl[i].e1, tbl[i].c1, (tbl[i].e1 == 8'h00)}) begin
        bad++;
        $display("FAIL reset[%0d] sat: got d=%h c=%b z=%b want d=%h c=%b", i, d1, fc1, fz1, tbl[i].e1, tbl[i].c1);
      end
    end
  endtask

  task automatic test_shift_rotate();
    step_t tbl[$];
    tbl = '{mk(1, 1, MODE_LOAD, 8'h81, 0, 0, 8'h81, 0, 8'h81, 0),
            mk(1, 1, MODE_SHL,  8'hFF, 1, 1, 8'h03, 1, 8'h03, 1),
            mk(1, 1, MODE_SHR,  8'hFF, 1, 0, 8'h01, 1, 8'h01, 1),
            mk(1, 1, MODE_ROR,  8'h00, 1, 1, 8'h80, 1, 8'h80, 1),
            mk(1, 1, MODE_ROL,  8'h00, 0, 1, 8'h01, 1, 8'h01, 1),
            mk(1, 1, MODE_SHL,  8'h00, 0, 0, 8'h02, 0, 8'h02, 0),
            mk(1, 1, MODE_SHR,  8'h00, 0, 1, 8'h81, 0, 8'h81, 0)};
    foreach (tbl[i]) begin
      drive(tbl[i]);
      tick();
      total++;
      if ({d0, fc0, fz0} !== {tbl[i].e0, tbl[i].c0, (tbl[i].e0 == 8'h00)}) begin
        bad++;
        $display("FAIL shift[%0d] wrap: got d=%h c=%b z=%b want d=%h c=%b", i, d0, fc0, fz0, tbl[i].e0, tbl[i].c0);
      end
      total++;
      if ({d1, fc1, fz1} !== {tbl[i].e1, tbl[i].c1, (tbl[i].e1 == 8'h00)}) begin
        bad++;
        $display("FAIL shift[%0d] sat: got d=%h c=%b z=%b want d=%h c=%b", i, d1, fc1, fz1, tbl[i].e1, tbl[i].c1);
      end
    end
  endtask

  task automatic test_inc_dec();
    step_t tbl[$];
    tbl = '{mk(1, 1, MODE_LOAD, 8'hFE, 0, 0, 8'hFE, 0, 8'hFE, 0),
            mk(1, 1, MODE_INC,  8'h00, 0, 0, 8'hFF, 0, 8'hFF, 0),
            mk(1, 1, MODE_INC,  8'h00, 0, 0, 8'h00, 1, 8'hFF, 1),
            mk(1, 1, MODE_DEC,  8'h00, 0, 0, 8'hFF, 1, 8'hFE, 0),
            mk(1, 1, MODE_LOAD, 8'hFF, 0, 0, 8'hFF, 0, 8'hFF, 0),
            mk(1, 1, MODE_INC,  8'h00, 0, 0, 8'h00, 1, 8'hFF, 1),
            mk(1, 1, MODE_INC,  8'h00, 0, 0, 8'h01, 0, 8'hFF, 1),
            mk(1, 1, MODE_INC,  8'h00, 0, 0, 8'h02, 0, 8'hFF, 1),
            mk(1, 1, MODE_LOAD, 8'h01, 0, 0, 8'h01, 0, 8'h01, 0),
            mk(1, 1, MODE_DEC,  8'h00, 0, 0, 8'h00, 0, 8'h00, 0),
            mk(1, 1, MODE_DEC,  8'h00, 0, 0, 8'hFF, 1, 8'h00, 1)};
    foreach (tbl[i]) begin
      drive(tbl[i]);
      tick();
      total++;
      if ({d0, fc0, fz0} !== {tbl[i].e0, tbl[i].c0, (tbl[i].e0 == 8'h00)}) begin
        bad++;
        $display("FAIL incdec[%0d] wrap: got d=%h c=%b z=%b want d=%h c=%b", i, d0, fc0, fz0, tbl[i].e0, tbl[i].c0);
      end
      total++;
      if ({d1, fc1, fz1} !== {tbl[i].e1, tbl[i].c1, (tbl[i].e1 == 8'h00)}) begin
        bad++;
        $display("FAIL incdec[%0d] sat: got d=%h c=%b z=%b want d=%h c=%b", i, d1, fc1, fz1, tbl[i].e1, tbl[i].c1);
      end
    end
  endtask

  task automatic test_enable_hold();
    step_t tbl[$];
    tbl = '{mk(1, 1, MODE_LOAD, 8'h79, 0, 0, 8'h79, 0, 8'h79, 0),
            mk(1, 1, MODE_SHR,  8'h00, 1, 0, 8'h3C, 1, 8'h3C, 1)};
    for (int m = 0; m < 8; m++)
      tbl.push_back(mk(1, 0, 3'(m), 8'hFF, 1, 1, 8'h3C, 1, 8'h3C, 1));
    tbl.push_back(mk(1, 1, MODE_HOLD, 8'hFF, 1, 1, 8'h3C, 1, 8'h3C, 1));
    foreach (tbl[i]) begin
      drive(tbl[i]);
      tick();
      total++;
      if ({d0, fc0, fz0} !== {tbl[i].e0, tbl[i].c0, (tbl[i].e0 == 8'h00)}) begin
        bad++;
        $display("FAIL enable[%0d] wrap: got d=%h c=%b z=%b want d=%h c=%b", i, d0, fc0, fz0, tbl[i].e0, tbl[i].c0);
      end
      total++;
      if ({d1, fc1, fz1} !== {tbl[i].e1, tbl[i].c1, (tbl[i].e1 == 8'h00)}) begin
        bad++;
        $display("FAIL enable[%0d] sat: got d=%h c=%b z=%b want d=%h c=%b", i, d1, fc1, fz1, tbl[i].e1, tbl[i].c1);
      end
    end
  endtask

  task automatic test_mid_reset();
    step_t tbl[$];
    tbl = '{mk(1, 1, MODE_LOAD, 8'h10, 0, 0, 8'h10, 0, 8'h10, 0),
            mk(1, 1, MODE_INC,  8'h00, 0, 0, 8'h11, 0, 8'h11, 0),
            mk(1, 1, MODE_INC,  8'h00, 0, 0, 8'h12, 0, 8'h12, 0),
            mk(0, 1, MODE_INC,  8'h00, 0, 0, 8'h00, 0, 8'h00, 0),
            mk(1, 1, MODE_INC,  8'h00, 0, 0, 8'h01, 0, 8'h01, 0)};
    foreach (tbl[i]) begin
      drive(tbl[i]);
      tick();
      total++;
      if ({d0, fc0, fz0} !== {tbl[i].e0, tbl[i].c0, (tbl[i].e0 == 8'h00)}) begin
        bad++;
        $display("FAIL midreset[%0d] wrap: got d=%h c=%b z=%b want d=%h c=%b", i, d0, fc0, fz0, tbl[i].e0, tbl[i].c0);
      end
      total++;
      if ({d1, fc1, fz1} !== {tbl[i].e1, tbl[i].c1, (tbl[i].e1 == 8'h00)}) begin
        bad++;
        $display("FAIL midreset[%0d] sat: got d=%h c=%b z=%b want d=%h c=%b", i, d1, fc1, fz1, tbl[i].e1, tbl[i].c1);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(0, 39) != 0);
      en       = ($urandom_range(0, 3) != 0);
      mode     = 3'($urandom_range(0, 7));
      data_in  = 8'($urandom);
      ser_in_l = 1'($urandom);
      ser_in_r = 1'($urandom);
      // Bias towards the rails so wrap and clamp paths get exercised often.
      if (mode == MODE_LOAD && $urandom_range(0, 1) == 1)
        data_in = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
      tick();
      total++;
      if ({d0, fc0, fz0} !== {8'(mv[0]), mc[0] != 0, mv[0] == 0}) begin
        bad++;
        $display("FAIL random[%0d] wrap: got d=%h c=%b z=%b want d=%h c=%0d", i, d0, fc0, fz0, 8'(mv[0]), mc[0]);
      end
      total++;
      if ({d1, fc1, fz1} !== {8'(mv[1]), mc[1] != 0, mv[1] == 0}) begin
        bad++;
        $display("FAIL random[%0d] sat: got d=%h c=%b z=%b want d=%h c=%0d", i, d1, fc1, fz1, 8'(mv[1]), mc[1]);
      end
    end
  endtask

  initial begin
    mv[0] = 0; mv[1] = 0;
    mc[0] = 0; mc[1] = 0;
    @(negedge clk);
    test_reset();
    test_shift_rotate();
    test_inc_dec();
    test_enable_hold();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
